// File: rtl/demux14_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : demux14_dispatch_if
// Brief    : Input stream, output lanes and status bundle for demux14_dispatch
// Revision : 1.0
// ============================================================================
interface demux14_dispatch_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_mode;
    logic               in_valid;
    logic               in_ready;
    logic               rr_clr;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [1:0]         rr_ptr;
    logic [CNT_W-1:0]   beat_cnt;
    logic               busy;

    modport master (
        output in_data, in_sel, in_mode, in_valid, rr_clr, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr, beat_cnt, busy
    );

    modport slave (
        input  in_data, in_sel, in_mode, in_valid, rr_clr, out_ready,
        output in_ready, out_data, out_valid, rr_ptr, beat_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/demux14_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : demux14_dispatch
// Brief    : 1-to-4 valid/ready dispatcher, one-beat holding register per lane
// Revision : 1.0
// ============================================================================
module demux14_dispatch #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input wire                clk,
    input wire                rst_n,
    demux14_dispatch_if.slave bus
);
    localparam int c_LANES = 4;

    logic [1:0]                      w_dest;
    logic                            w_in_ready;
    logic                            w_accept;
    logic [c_LANES-1:0]              w_load;
    logic [c_LANES-1:0]              w_pop;

    logic [c_LANES-1:0]              valid_q, valid_d;
    logic [c_LANES-1:0][WIDTH-1:0]   data_q,  data_d;
    logic [1:0]                      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]                beat_cnt_q, beat_cnt_d;

    // A full lane that drains this cycle may be reloaded in the same cycle.
    always_comb begin
        w_dest     = bus.in_mode ? rr_ptr_q : bus.in_sel;
        w_in_ready = !valid_q[w_dest] || bus.out_ready[w_dest];
        w_accept   = bus.in_valid && w_in_ready;
    end

    generate
        for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
            assign w_load[gi]  = w_accept && (w_dest == 2'(gi));
            assign w_pop[gi]   = valid_q[gi] && bus.out_ready[gi];
            assign valid_d[gi] = w_load[gi] || (valid_q[gi] && !w_pop[gi]);
            assign data_d[gi]  = w_load[gi] ? bus.in_data : data_q[gi];
        end
    endgenerate

    // Clear wins over increment; the beat in the clear cycle uses the old pointer.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (bus.rr_clr) begin
            rr_ptr_d = 2'd0;
        end else if (w_accept && bus.in_mode) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
        end
        if (w_accept) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            data_q     <= '0;
            rr_ptr_q   <= 2'd0;
            beat_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.rr_ptr    = rr_ptr_q;
    assign bus.beat_cnt  = beat_cnt_q;
    assign bus.busy      = |valid_q;

endmodule
`default_nettype wire

// File: tb/tb_demux14_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux14_dispatch
// Brief    : Directed and randomized checks of demux14_dispatch against a queue model
// Revision : 1.0
// ============================================================================
module tb_demux14_dispatch;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux14_dispatch_if #(.WIDTH(8), .CNT_W(16)) bus  ();
    demux14_dispatch_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

    assign bus4.in_data   = bus.in_data;
    assign bus4.in_sel    = bus.in_sel;
    assign bus4.in_mode   = bus.in_mode;
    assign bus4.in_valid  = bus.in_valid;
    assign bus4.rr_clr    = bus.rr_clr;
    assign bus4.out_ready = bus.out_ready;

    demux14_dispatch #(.WIDTH(8), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    demux14_dispatch #(.WIDTH(8), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Reference: each lane is a queue of at most one pending beat.
    logic [7:0]  m_lane [4][$];
    logic [7:0]  m_last [4];
    int unsigned m_rr;
    int unsigned m_cnt;
    int n_vec = 0;
    int n_err = 0;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_lane[i].delete();
            m_last[i] = 8'h00;
        end
        m_rr  = 0;
        m_cnt = 0;
    endfunction

    function automatic int m_dest();
        return bus.in_mode ? int'(m_rr) : int'(bus.in_sel);
    endfunction

    function automatic logic m_ready();
        int d;
        d = m_dest();
        return (m_lane[d].size() == 0) || bus.out_ready[d];
    endfunction

    function automatic logic [3:0] m_valid();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (m_lane[i].size() != 0);
        return v;
    endfunction

    function automatic logic [31:0] m_data();
        return {m_last[3], m_last[2], m_last[1], m_last[0]};
    endfunction

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_sel    = 2'd0;
        bus.in_mode   = 1'b0;
        bus.rr_clr    = 1'b0;
        bus.out_ready = 4'b0000;
    endtask

    // One clock edge: samples inputs, advances the model, returns 1 ns after the edge.
    task automatic tick();
        int         d;
        logic       acc;
        logic       clr;
        logic       mode;
        logic [7:0] din;
        logic [3:0] ordy;
        d    = m_dest();
        acc  = bus.in_valid && m_ready();
        clr  = bus.rr_clr;
        mode = bus.in_mode;
        din  = bus.in_data;
        ordy = bus.out_ready;
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (m_lane[i].size() != 0 && ordy[i]) void'(m_lane[i].pop_front());
        if (acc) begin
            m_lane[d].push_back(din);
            m_last[d] = din;
            m_cnt++;
        end
        if (clr) m_rr = 0;
        else if (acc && mode) m_rr = (m_rr + 1) % 4;
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        n_vec++; if (bus.out_valid !== 4'b0000) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0000", bus.out_valid); end
        n_vec++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 00000000", bus.out_data); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_vec++; if (bus.rr_ptr !== 2'd0) begin n_err++; $display("FAIL reset_rr_ptr: got %0d expected 0", bus.rr_ptr); end
        n_vec++; if (bus.beat_cnt !== 16'd0) begin n_err++; $display("FAIL reset_beat_cnt: got %0d expected 0", bus.beat_cnt); end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_addressed();
        apply_reset();
        bus.in_sel = 2'd2; bus.in_data = 8'hA5; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_vec++; if (bus.out_valid !== 4'b0100) begin n_err++; $display("FAIL addr_out_valid: got %b expected 0100", bus.out_valid); end
        n_vec++; if (bus.out_data[16 +: 8] !== 8'hA5) begin n_err++; $display("FAIL addr_lane2_data: got %h expected a5", bus.out_data[16 +: 8]); end
        n_vec++; if (bus.beat_cnt !== 16'd1) begin n_err++; $display("FAIL addr_beat_cnt: got %0d expected 1", bus.beat_cnt); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL addr_busy: got %b expected 1", bus.busy); end
        bus.in_sel = 2'd2; bus.in_data = 8'h5A; bus.in_valid = 1'b1;
        #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL addr_full_lane_ready: got %b expected 0", bus.in_ready); end
        tick();
        n_vec++; if (bus.out_data[16 +: 8] !== 8'hA5) begin n_err++; $display("FAIL addr_lane2_held: got %h expected a5", bus.out_data[16 +: 8]); end
        bus.in_sel = 2'd1; bus.in_data = 8'h3C;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL addr_lane1_ready: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_vec++; if (bus.out_valid !== 4'b0110) begin n_err++; $display("FAIL addr_two_lanes_valid: got %b expected 0110", bus.out_valid); end
        n_vec++; if (bus.out_data[8 +: 8] !== 8'h3C) begin n_err++; $display("FAIL addr_lane1_data: got %h expected 3c", bus.out_data[8 +: 8]); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.in_mode = 1'b1; bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_data = 8'h10 + 8'(k);
            #1;
            n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rr_in_ready beat %0d: got %b expected 1", k, bus.in_ready); end
            tick();
            n_vec++; if (bus.out_valid[k % 4] !== 1'b1 || bus.out_data[(k % 4) * 8 +: 8] !== 8'h10 + 8'(k))
                begin n_err++; $display("FAIL rr_lane beat %0d: got valid=%b data=%h expected valid=1 data=%h in lane %0d", k, bus.out_valid, bus.out_data[(k % 4) * 8 +: 8], 8'h10 + 8'(k), k % 4); end
        end
        bus.in_valid = 1'b0;
        n_vec++; if (bus.rr_ptr !== 2'd0) begin n_err++; $display("FAIL rr_ptr_wrap: got %0d expected 0", bus.rr_ptr); end
        n_vec++; if (bus.beat_cnt !== 16'd8) begin n_err++; $display("FAIL rr_beat_cnt: got %0d expected 8", bus.beat_cnt); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.in_sel = 2'd3; bus.in_data = 8'h33; bus.in_valid = 1'b1;
        tick();
        bus.in_data = 8'h44;
        #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready: got %b expected 0", bus.in_ready); end
        tick();
        n_vec++; if (bus.out_valid[3] !== 1'b1 || bus.out_data[24 +: 8] !== 8'h33) begin n_err++; $display("FAIL b2b_lane3_held: got valid=%b data=%h expected 1/33", bus.out_valid[3], bus.out_data[24 +: 8]); end
        bus.out_ready = 4'b1000;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_same_cycle_ready: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
        n_vec++; if (bus.out_valid[3] !== 1'b1 || bus.out_data[24 +: 8] !== 8'h44) begin n_err++; $display("FAIL b2b_reload: got valid=%b data=%h expected 1/44", bus.out_valid[3], bus.out_data[24 +: 8]); end
        n_vec++; if (bus.beat_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_beat_cnt: got %0d expected 2", bus.beat_cnt); end
    endtask

    task automatic test_rr_clr();
        apply_reset();
        bus.in_mode = 1'b1; bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
        bus.in_data = 8'hE0; tick();
        bus.in_data = 8'hE1; tick();
        bus.in_valid = 1'b0;
        #1;
        n_vec++; if (bus.rr_ptr !== 2'd2) begin n_err++; $display("FAIL clr_pre_ptr: got %0d expected 2", bus.rr_ptr); end
        bus.in_valid = 1'b1; bus.in_data = 8'hC2; bus.rr_clr = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.rr_clr = 1'b0;
        n_vec++; if (bus.out_valid !== 4'b0100 || bus.out_data[16 +: 8] !== 8'hC2) begin n_err++; $display("FAIL clr_beat_lane2: got valid=%b data=%h expected 0100/c2", bus.out_valid, bus.out_data[16 +: 8]); end
        n_vec++; if (bus.rr_ptr !== 2'd0) begin n_err++; $display("FAIL clr_post_ptr: got %0d expected 0", bus.rr_ptr); end
    endtask

    task automatic test_cnt_wrap();
        apply_reset();
        bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            bus.in_sel  = 2'($urandom);
            bus.in_data = 8'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        n_vec++; if (bus4.beat_cnt !== 4'd1) begin n_err++; $display("FAIL cnt4_wrap: got %0d expected 1", bus4.beat_cnt); end
        n_vec++; if (bus.beat_cnt !== 16'd17) begin n_err++; $display("FAIL cnt16_no_wrap: got %0d expected 17", bus.beat_cnt); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.in_mode = 1'b1; bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_data = 8'hD0 + 8'(k);
            tick();
        end
        bus.in_valid = 1'b0; bus.in_mode = 1'b0;
        n_vec++; if (bus.out_valid !== 4'b1111) begin n_err++; $display("FAIL arst_fill: got %b expected 1111", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 4'b0000 || bus.busy !== 1'b0) begin n_err++; $display("FAIL arst_immediate: got valid=%b busy=%b expected 0000/0", bus.out_valid, bus.busy); end
        model_reset();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready: got %b expected 1", bus.in_ready); end
        n_vec++; if (bus.rr_ptr !== 2'd0 || bus.beat_cnt !== 16'd0) begin n_err++; $display("FAIL arst_state: got rr_ptr=%0d beat_cnt=%0d expected 0/0", bus.rr_ptr, bus.beat_cnt); end
    endtask

    task automatic test_random();
        logic hold;
        apply_reset();
        hold = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!hold) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_data  = 8'($urandom);
                bus.in_sel   = 2'($urandom);
                bus.in_mode  = 1'($urandom);
            end
            bus.out_ready = 4'($urandom);
            bus.rr_clr    = ($urandom_range(0, 15) == 0);
            #1;
            n_vec++; if (bus.in_ready !== m_ready()) begin n_err++; $display("FAIL rnd_in_ready cyc %0d: got %b expected %b", k, bus.in_ready, m_ready()); end
            hold = bus.in_valid && !m_ready();
            tick();
            n_vec++; if (bus.out_valid !== m_valid()) begin n_err++; $display("FAIL rnd_out_valid cyc %0d: got %b expected %b", k, bus.out_valid, m_valid()); end
            n_vec++; if (bus.out_data !== m_data()) begin n_err++; $display("FAIL rnd_out_data cyc %0d: got %h expected %h", k, bus.out_data, m_data()); end
            n_vec++; if (bus.busy !== (m_valid() != 4'b0000)) begin n_err++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", k, bus.busy, m_valid() != 4'b0000); end
            n_vec++; if (bus.rr_ptr !== 2'(m_rr)) begin n_err++; $display("FAIL rnd_rr_ptr cyc %0d: got %0d expected %0d", k, bus.rr_ptr, m_rr); end
            n_vec++; if (bus.beat_cnt !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_beat_cnt cyc %0d: got %0d expected %0d", k, bus.beat_cnt, 16'(m_cnt)); end
            n_vec++; if (bus4.beat_cnt !== 4'(m_cnt)) begin n_err++; $display("FAIL rnd_beat_cnt4 cyc %0d: got %0d expected %0d", k, bus4.beat_cnt, 4'(m_cnt)); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_addressed();
        test_round_robin();
        test_back_to_back();
        test_rr_clr();
        test_cnt_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
